// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: walks IF/ID/EXE/MEM/WB,
// picks the next PC and strobes PCWre on the final state.
module pc_sequencer (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        sign,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  input  logic [31:0] cur_pc,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        PCWre,
  output logic        IRWre,
  output logic        RegWre,
  output logic [2:0]  state,
  output logic        halted
);

  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_BLTZ = 6'b110010;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111001;
  localparam logic [5:0] OP_JR   = 6'b111010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t st;
  state_t st_nxt;

  logic is_br;
  logic is_jmp;
  logic is_jal;
  logic is_jr;
  logic is_ld;
  logic is_st;
  logic is_halt;
  logic taken;
  logic last;
  logic go;
  logic [31:0] pc4;

  // Opcode class decode
  always_comb begin
    is_br   = 1'b0;
    is_jmp  = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_halt = 1'b0;
    unique case (1'b1)
      (opcode == OP_BEQ),
      (opcode == OP_BNE),
      (opcode == OP_BLTZ): is_br = 1'b1;
      (opcode == OP_J):    is_jmp = 1'b1;
      (opcode == OP_JAL): begin
        is_jmp = 1'b1;
        is_jal = 1'b1;
      end
      (opcode == OP_JR): begin
        is_jmp = 1'b1;
        is_jr  = 1'b1;
      end
      (opcode == OP_LW):   is_ld = 1'b1;
      (opcode == OP_SW):   is_st = 1'b1;
      (opcode == OP_HALT): is_halt = 1'b1;
      default: ;
    endcase
  end

  // Next-state selection; stall freezes the walk
  always_comb begin
    st_nxt = st;
    if (!stall) begin
      unique case (st)
        S_IF:  st_nxt = S_ID;
        S_ID: begin
          if (is_halt)     st_nxt = S_HALT;
          else if (is_jmp) st_nxt = S_IF;
          else             st_nxt = S_EXE;
        end
        S_EXE: begin
          if (is_br)               st_nxt = S_IF;
          else if (is_ld || is_st) st_nxt = S_MEM;
          else                     st_nxt = S_WB;
        end
        S_MEM: st_nxt = is_ld ? S_WB : S_IF;
        S_WB:  st_nxt = S_IF;
        S_HALT: st_nxt = S_HALT;
        default: st_nxt = S_IF;
      endcase
    end
  end

  // State register, async clear back to IF
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) st <= S_IF;
    else        st <= st_nxt;
  end

  // Strobes: reset forces PCWre so the PC register clears
  always_comb begin
    taken = (st == S_EXE) &&
            (((opcode == OP_BEQ) && zero) ||
             ((opcode == OP_BNE) && !zero) ||
             ((opcode == OP_BLTZ) && sign));
    last  = (st == S_WB) ||
            ((st == S_MEM) && is_st) ||
            ((st == S_EXE) && is_br) ||
            ((st == S_ID) && is_jmp);
    go     = Reset && !stall;
    PCWre  = !Reset || (go && last);
    IRWre  = go && (st == S_IF);
    RegWre = go && ((st == S_WB) ||
                    ((st == S_ID) && is_jal));
    halted = Reset && (st == S_HALT);
    state  = st;
  end

  // Next PC mux
  always_comb begin
    pc4 = cur_pc + 32'd4;
    if (!Reset)
      next_pc = 32'd0;
    else if (taken)
      next_pc = pc4 + (imm_ext << 2);
    else if (is_jmp && !is_jr)
      next_pc = {pc4[31:28], jaddr, 2'b00};
    else if (is_jr)
      next_pc = rs_data;
    else
      next_pc = pc4;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: random
// instructions against a path/next-PC model.
module tb_pc_sequencer;

  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_BLTZ = 6'b110010;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JAL  = 6'b111001;
  localparam logic [5:0] OP_JR   = 6'b111010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] imm_ext = '0;
  logic [25:0] jaddr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] cur_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] next_pc;
  logic        PCWre;
  logic        IRWre;
  logic        RegWre;
  logic [2:0]  state;
  logic        halted;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode),
    .zero(zero), .sign(sign), .imm_ext(imm_ext),
    .jaddr(jaddr), .rs_data(rs_data),
    .cur_pc(cur_pc), .stall(stall),
    .next_pc(next_pc), .PCWre(PCWre),
    .IRWre(IRWre), .RegWre(RegWre),
    .state(state), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] trace;
    logic [31:0] npc;
    int          irc;
    int          rgc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] pc_reg = 32'hDEADBEEF;
  always @(posedge CLK) if (PCWre) pc_reg <= next_pc;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, req);
    end
  endtask

  // Reference: path (state+1 per nibble), target,
  // and strobe counts per instruction
  function automatic exp_t model(
    logic [5:0] op, logic z, logic s,
    logic [31:0] imm, logic [25:0] ja,
    logic [31:0] rs, logic [31:0] pc);
    exp_t e;
    logic [31:0] p4;
    logic tk;
    p4 = pc + 32'd4;
    e.npc = p4;
    e.irc = 1;
    e.rgc = 0;
    if (op == OP_BEQ || op == OP_BNE ||
        op == OP_BLTZ) begin
      e.trace = 32'h123;
      if (op == OP_BEQ)      tk = z;
      else if (op == OP_BNE) tk = !z;
      else                   tk = s;
      if (tk) e.npc = p4 + imm * 32'd4;
    end else if (op == OP_J || op == OP_JAL) begin
      e.trace = 32'h12;
      e.npc = {p4[31:28], ja, 2'b00};
      e.rgc = (op == OP_JAL) ? 1 : 0;
    end else if (op == OP_JR) begin
      e.trace = 32'h12;
      e.npc = rs;
    end else if (op == OP_LW) begin
      e.trace = 32'h12345;
      e.rgc = 1;
    end else if (op == OP_SW) begin
      e.trace = 32'h1234;
    end else begin
      e.trace = 32'h1235;
      e.rgc = 1;
    end
    return e;
  endfunction

  logic [31:0] trace = '0;
  int irc = 0;
  int rgc = 0;

  // Monitor: a PCWre pulse closes an instruction
  always @(negedge CLK) begin
    if (!Reset) begin
      trace = '0;
      irc = 0;
      rgc = 0;
    end else begin
      irc += int'(IRWre);
      rgc += int'(RegWre);
      if (!stall) trace = (trace << 4) | 32'(state + 3'd1);
      if (PCWre) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", 32'(exp_q.size()), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("path", trace, e.trace);
          chk("next_pc", next_pc, e.npc);
          chk("irwre_cnt", irc, e.irc);
          chk("regwre_cnt", rgc, e.rgc);
        end
        trace = '0;
        irc = 0;
        rgc = 0;
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b0;
    stall = 1'b1;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pcwre", 32'(PCWre), 1);
    chk("rst_strobes", {IRWre, RegWre, halted}, 0);
    chk("rst_next_pc", next_pc, 0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_hold", {state, PCWre}, 4'b0001);
    @(posedge CLK);
    #2;
    exp_q.delete();
    Reset = 1'b1;
    stall = 1'b0;
  endtask

  // mode 0: no stall, 1: random stall, 2: 3 stalls in MEM
  task automatic run_instr(
    logic [5:0] op, logic z, logic s,
    logic [31:0] imm, logic [25:0] ja,
    logic [31:0] rs, logic [31:0] pc, int mode);
    int held;
    logic done;
    opcode = op;
    zero = z;
    sign = s;
    imm_ext = imm;
    jaddr = ja;
    rs_data = rs;
    cur_pc = pc;
    exp_q.push_back(model(op, z, s, imm, ja, rs, pc));
    held = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (mode == 1)
        stall = ($urandom_range(0, 3) == 0);
      else if (mode == 2)
        stall = (state == 3'd3) && (held < 3);
      else
        stall = 1'b0;
      if (mode == 2 && stall) held++;
      @(negedge CLK);
      if (mode == 2 && stall)
        chk("stall_hold",
            {state, PCWre, IRWre, RegWre}, 6'b011000);
      done = PCWre;
      @(posedge CLK);
      #2;
    end
    stall = 1'b0;
    chk("commit_seen", 32'(done), 1);
    if (!done) do_reset();
  endtask

  task automatic run_halt();
    opcode = OP_HALT;
    stall = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    for (int i = 0; i < 10; i++) begin
      stall = $urandom_range(0, 1) == 1;
      @(negedge CLK);
      chk("halt_hold",
          {state, halted, PCWre, IRWre, RegWre},
          7'b1011000);
      @(posedge CLK);
      #2;
    end
    stall = 1'b0;
    #1;
    do_reset();
  endtask

  task automatic abort_exe();
    opcode = 6'h05;
    stall = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("mid_exe", 32'(state), 2);
    #1;
    do_reset();
  endtask

  logic [5:0] ops [9];

  initial begin
    ops = '{OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JAL,
            OP_JR, OP_SW, OP_LW, 6'h00};
    do_reset();
    chk("pc_reg_clear", pc_reg, 0);

    run_instr(6'h01, 0, 0, 0, 0, 0, 32'h100, 0);
    run_instr(OP_BEQ, 1, 0, 32'hFFFFFFFE, 0, 0,
              32'h10, 0);
    run_instr(OP_BEQ, 0, 0, 32'hFFFFFFFE, 0, 0,
              32'h10, 0);
    run_instr(OP_J, 0, 0, 0, 26'h0000040, 0,
              32'hF0000000, 0);
    run_instr(OP_JR, 0, 0, 0, 0, 32'h2000,
              32'h40, 0);
    run_instr(OP_LW, 0, 0, 0, 0, 0, 32'h200, 2);
    run_instr(6'h02, 0, 0, 0, 0, 0,
              32'hFFFFFFFC, 0);
    run_instr(OP_JAL, 0, 0, 0, 26'h3FFFFFF, 0,
              32'h1234, 0);
    run_instr(OP_BLTZ, 0, 1, 32'h4, 0, 0,
              32'h20, 0);
    run_instr(OP_SW, 0, 0, 0, 0, 0, 32'h300, 0);
    abort_exe();

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 8)];
      if (op == 6'h00) op = 6'($urandom_range(0, 37));
      run_instr(op, 1'($urandom), 1'($urandom),
                $urandom, 26'($urandom), $urandom,
                $urandom, 1);
    end

    run_halt();
    run_instr(6'h03, 0, 0, 0, 0, 0, 32'h8, 1);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
